// File: rtl/soc_system_pio_out_pkg.sv
// Shared definitions for the output PIO slave.
// Word addresses of the register map, pulse engine state encoding and the
// bit position of the busy flag in the PULSE readback word.
package soc_system_pio_out_pkg;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd1;
  localparam logic [2:0] ADDR_CLEAR = 3'd2;
  localparam logic [2:0] ADDR_PLEN  = 3'd3;
  localparam logic [2:0] ADDR_PULSE = 3'd4;

  localparam int BUSY_BIT = 31;

  typedef enum logic {
    IDLE,
    ACTIVE
  } pulse_state_t;

endpackage

// File: rtl/soc_system_pio_out_pulse.sv
// Timed pulse engine for the output PIO.
// A valid start (nonzero mask and nonzero length) loads the mask and the
// length counter; the mask stays asserted for exactly plen cycles. A valid
// start while active restarts with the new mask (no merge), including on the
// final countdown cycle. Invalid starts are ignored.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             PULSE register write strobe
//   mask_in           requested toggle mask
//   plen              programmed pulse length in cycles
//   mask              currently applied toggle mask
//   busy              high while a pulse is in progress
module soc_system_pio_out_pulse
  import soc_system_pio_out_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PULSE_LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  mask_in,
  input  logic [PULSE_LEN_W-1:0] plen,
  output logic [DATA_WIDTH-1:0]  mask,
  output logic                   busy
);

  localparam logic [PULSE_LEN_W-1:0] CNT_ONE = PULSE_LEN_W'(1);

  pulse_state_t           state_q;
  logic [PULSE_LEN_W-1:0] cnt_q;
  logic                   start_ok;

  assign start_ok = start && (plen != '0) && (mask_in != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask    <= '0;
      cnt_q   <= '0;
    end else if (start_ok) begin
      state_q <= ACTIVE;
      mask    <= mask_in;
      cnt_q   <= plen;
    end else begin
      case (state_q)
        IDLE: ;
        ACTIVE: begin
          // Terminal count also covers a zero count so the counter never wraps.
          if (cnt_q <= CNT_ONE) begin
            state_q <= IDLE;
            mask    <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == ACTIVE);

endmodule

// File: rtl/soc_system_pio_out.sv
// Avalon-MM output PIO slave: HPS-written registers drive out_port.
// Supports direct load, atomic set/clear and (optionally) a timed pulse
// engine whose mask is XORed onto the data register.
// Build option: define PIO_OUT_PULSE_EN to include the PLEN/PULSE registers
// and the pulse engine; otherwise addresses 3/4 read 0 and ignore writes.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   address      register word address
//   write        one-cycle write strobe
//   writedata    write data (bits above DATA_WIDTH ignored for data regs)
//   readdata     registered read data, one cycle latency
//   out_port     data_q XOR pulse mask
module soc_system_pio_out
  import soc_system_pio_out_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PULSE_LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] wd;
  logic [31:0]           rd_next;
  logic                  unused_ok;

  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_ok = &{1'b0, writedata};

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (write) begin
      case (address)
        ADDR_DATA:  data_q <= wd;
        ADDR_SET:   data_q <= data_q | wd;
        ADDR_CLEAR: data_q <= data_q & ~wd;
        default:    ;
      endcase
    end
  end

`ifdef PIO_OUT_PULSE_EN
  logic [PULSE_LEN_W-1:0] plen_q;
  logic [DATA_WIDTH-1:0]  pulse_mask;
  logic                   pulse_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      plen_q <= '0;
    end else if (write && (address == ADDR_PLEN)) begin
      plen_q <= writedata[PULSE_LEN_W-1:0];
    end
  end

  soc_system_pio_out_pulse #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PULSE_LEN_W (PULSE_LEN_W)
  ) u_pulse (
    .clk     (clk),
    .reset   (reset),
    .start   (write && (address == ADDR_PULSE)),
    .mask_in (wd),
    .plen    (plen_q),
    .mask    (pulse_mask),
    .busy    (pulse_busy)
  );

  assign out_port = data_q ^ pulse_mask;
`else
  localparam int unused_plen_w = PULSE_LEN_W;
  assign out_port = data_q;
`endif

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next = 32'(data_q);
      ADDR_SET:  rd_next = 32'(out_port);
`ifdef PIO_OUT_PULSE_EN
      ADDR_PLEN: rd_next = 32'(plen_q);
      ADDR_PULSE: begin
        rd_next           = 32'(pulse_mask);
        rd_next[BUSY_BIT] = pulse_busy;
      end
`endif
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_soc_system_pio_out.sv
// Self-checking bench for soc_system_pio_out (DATA_WIDTH=8, PULSE_LEN_W=16).
// Pulse sequences are exercised when PIO_OUT_PULSE_EN is defined; otherwise
// addresses 3/4 are checked to read 0 and ignore writes.
module tb_soc_system_pio_out;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [31:0] rd_q[$];

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  eo;
    logic [31:0] er;
  } vec_t;

  vec_t tbl[8];

  soc_system_pio_out #(
    .DATA_WIDTH  (8),
    .PULSE_LEN_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, queue the expected readdata, check after the edge.
  task automatic step(input string name, input logic [2:0] a, input logic w,
                      input logic [31:0] d, input logic [7:0] eo, input logic [31:0] er);
    logic [31:0] exp_rd;
    address   = a;
    write     = w;
    writedata = d;
    rd_q.push_back(er);
    @(posedge clk);
    #1;
    write = 1'b0;
    if (rd_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_rd = rd_q.pop_front();
      chk({name, "_rd"}, readdata, exp_rd);
    end
    chk({name, "_out"}, {24'd0, out_port}, {24'd0, eo});
  endtask

  task automatic do_reset(input string name, input int unsigned cycles);
    reset = 1'b1;
    write = 1'b0;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    chk({name, "_out"}, {24'd0, out_port}, 32'd0);
    chk({name, "_rd"}, readdata, 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    address   = 3'd0;
    write     = 1'b0;
    writedata = '0;

    tbl[0] = '{3'd0, 1'b1, 32'h0000_00A5, 8'hA5, 32'h0000_0000};
    tbl[1] = '{3'd1, 1'b1, 32'h0000_000F, 8'hAF, 32'h0000_00A5};
    tbl[2] = '{3'd2, 1'b1, 32'h0000_0081, 8'h2E, 32'h0000_0000};
    tbl[3] = '{3'd0, 1'b0, 32'h0000_0000, 8'h2E, 32'h0000_002E};
    tbl[4] = '{3'd1, 1'b0, 32'h0000_0000, 8'h2E, 32'h0000_002E};
    tbl[5] = '{3'd6, 1'b0, 32'h0000_0000, 8'h2E, 32'h0000_0000};
    tbl[6] = '{3'd6, 1'b1, 32'hFFFF_FFFF, 8'h2E, 32'h0000_0000};
    tbl[7] = '{3'd5, 1'b1, 32'h0000_00FF, 8'h2E, 32'h0000_0000};

    do_reset("reset", 2);
    step("reset_idle_rd4", 3'd4, 1'b0, 32'h0, 8'h00, 32'h0);

    for (int i = 0; i < 8; i++) begin
      step($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].eo, tbl[i].er);
    end

`ifdef PIO_OUT_PULSE_EN
    // Basic pulse: 0x03 over 0x2E for 4 cycles.
    step("plen4", 3'd3, 1'b1, 32'd4, 8'h2E, 32'd0);
    step("pulse03", 3'd4, 1'b1, 32'h03, 8'h2D, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("pulse_hold%0d", i), 3'd4, 1'b0, 32'h0, 8'h2D, 32'h8000_0003);
    end
    step("pulse_end", 3'd4, 1'b0, 32'h0, 8'h2E, 32'h8000_0003);
    step("pulse_idle", 3'd4, 1'b0, 32'h0, 8'h2E, 32'h0);

    // Retrigger: 0x01, then 0x80 three cycles later held for 10 cycles.
    step("plen10", 3'd3, 1'b1, 32'd10, 8'h2E, 32'd4);
    step("pulse01", 3'd4, 1'b1, 32'h01, 8'h2F, 32'd0);
    step("rt_wait0", 3'd4, 1'b0, 32'h0, 8'h2F, 32'h8000_0001);
    step("rt_wait1", 3'd4, 1'b0, 32'h0, 8'h2F, 32'h8000_0001);
    step("pulse80", 3'd4, 1'b1, 32'h80, 8'hAE, 32'h8000_0001);
    for (int i = 0; i < 9; i++) begin
      step($sformatf("rt_hold%0d", i), 3'd4, 1'b0, 32'h0, 8'hAE, 32'h8000_0080);
    end
    step("rt_end", 3'd4, 1'b0, 32'h0, 8'h2E, 32'h8000_0080);

    // Zero length: pulse write ignored.
    step("plen0", 3'd3, 1'b1, 32'd0, 8'h2E, 32'd10);
    step("pulse_ff_ign", 3'd4, 1'b1, 32'hFF, 8'h2E, 32'd0);
    step("pulse_ff_rd", 3'd4, 1'b0, 32'h0, 8'h2E, 32'd0);
`else
    step("plen_wr_ign", 3'd3, 1'b1, 32'd4, 8'h2E, 32'd0);
    step("plen_rd0", 3'd3, 1'b0, 32'd0, 8'h2E, 32'd0);
    step("pulse_wr_ign", 3'd4, 1'b1, 32'h03, 8'h2E, 32'd0);
    step("pulse_rd0", 3'd4, 1'b0, 32'h0, 8'h2E, 32'd0);
`endif

    // Upper writedata bits are dropped from the data register.
    step("data_hi", 3'd0, 1'b1, 32'hFFFF_FF00, 8'h00, 32'h2E);
    step("data_hi_rd", 3'd0, 1'b0, 32'h0, 8'h00, 32'h0);
    step("data_55", 3'd0, 1'b1, 32'h55, 8'h55, 32'h0);

`ifdef PIO_OUT_PULSE_EN
    step("plen5", 3'd3, 1'b1, 32'd5, 8'h55, 32'd0);
    step("pulse10", 3'd4, 1'b1, 32'h10, 8'h45, 32'd0);
    step("pulse10_hold", 3'd4, 1'b0, 32'h0, 8'h45, 32'h8000_0010);
`endif
    do_reset("midreset", 1);
    step("post_reset_rd4", 3'd4, 1'b0, 32'h0, 8'h00, 32'h0);
    step("post_reset_rd3", 3'd3, 1'b0, 32'h0, 8'h00, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
